// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite request arbiter.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Position 'offset' slots after 'base' in a ring of n entries.
  function automatic int rr_slot(int base, int offset, int n);
    int s;
    s = base + offset;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  // Scan the ring starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_o && req_i[rr_slot(int'(ptr_i), i, NUM_REQ)]) begin
        any_o = 1'b1;
        gnt_o[rr_slot(int'(ptr_i), i, NUM_REQ)] = 1'b1;
        idx_o = IW'(rr_slot(int'(ptr_i), i, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares one AXI-Lite master command port among NUM_REQ requesters, one
// transaction at a time, with a hung-slave timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate among pending requests
// ST_ISSUE | req_ready and start pulse visible; address/data presented
// ST_WAIT  | waiting for R or B handshake on the tapped channel, timer runs
// ST_RESP  | rsp_valid pulse to the granted requester
module axi_lite_req_arbiter
  import axi_lite_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int TIMEOUT_CYC = 256,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      mst_start_rd,
  output logic                      mst_start_wr,
  output logic [ADDR_W-1:0]         mst_addr,
  output logic [DATA_W-1:0]         mst_wdata,
  input  logic                      mon_rvalid,
  input  logic                      mon_rready,
  input  logic [DATA_W-1:0]         mon_rdata,
  input  logic [1:0]                mon_rresp,
  input  logic                      mon_bvalid,
  input  logic                      mon_bready,
  input  logic [1:0]                mon_bresp,
  output logic                      busy,
  output logic [IW-1:0]             grant_id,
  output logic                      timeout_err
);

  // Timer is a down-counter loaded so that it reaches zero on the last
  // allowed WAIT cycle.
  localparam int              TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   TIMER_LOAD = (TIMEOUT_CYC > 1) ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYC > 0);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_t           state_q;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        rr_ptr_q;
  logic                 write_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]    rsp_rdata_q;
  logic [1:0]           rsp_resp_q;
  logic                 start_rd_q;
  logic                 start_wr_q;
  logic [TW-1:0]        timer_q;
  logic                 timeout_err_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;

  logic [ADDR_W-1:0]    sel_addr_d;
  logic [DATA_W-1:0]    sel_wdata_d;
  logic                 sel_write_d;
  logic [IW-1:0]        rr_ptr_d;
  logic                 done_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Select the winning requester's command and compute the next pointer.
  always_comb begin
    sel_addr_d  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
    sel_wdata_d = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
    sel_write_d = req_write[arb_idx];
    rr_ptr_d    = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
  end

  // Only the handshake on the channel matching the latched type ends WAIT.
  always_comb begin
    done_d = write_q ? (mon_bvalid & mon_bready) : (mon_rvalid & mon_rready);
  end

  // Sequencer: arbitration, start pulse, completion/timeout, response pulse.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      rr_ptr_q      <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      start_rd_q    <= 1'b0;
      start_wr_q    <= 1'b0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      start_rd_q  <= 1'b0;
      start_wr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            idx_q       <= arb_idx;
            write_q     <= sel_write_d;
            addr_q      <= sel_addr_d;
            wdata_q     <= sel_wdata_d;
            req_ready_q <= arb_gnt;
            start_wr_q  <= sel_write_d;
            start_rd_q  <= !sel_write_d;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= TIMER_LOAD;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_d) begin
            rsp_rdata_q <= write_q ? '0 : mon_rdata;
            rsp_resp_q  <= write_q ? mon_bresp : mon_rresp;
            rsp_valid_q <= ONE_HOT0 << idx_q;
            state_q     <= ST_RESP;
          end else if (TIMEOUT_EN && (timer_q == '0)) begin
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_DECERR;
            rsp_valid_q   <= ONE_HOT0 << idx_q;
            timeout_err_q <= 1'b1;
            state_q       <= ST_RESP;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_resp     = rsp_resp_q;
  assign mst_start_rd = start_rd_q;
  assign mst_start_wr = start_wr_q;
  assign mst_addr     = (state_q == ST_ISSUE || state_q == ST_WAIT) ? addr_q  : '0;
  assign mst_wdata    = (state_q == ST_ISSUE || state_q == ST_WAIT) ? wdata_q : '0;
  assign busy         = (state_q != ST_IDLE);
  assign grant_id     = idx_q;
  assign timeout_err  = timeout_err_q;

endmodule
